// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter for the debug serial link.
// Bytes arrive over a valid/ready handshake and are queued in a circular
// FIFO. A four-state FSM (IDLE/START/DATA/STOP) shifts them out LSB-first.
// The line output is registered, so it trails the FSM state by one clock.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_serial_q, tx_serial_d;

  logic [7:0]      mem [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            baud_done;

  // Handshake and flow-control flags derived from the stored occupancy.
  always_comb begin
    tx_ready   = (count_q != CW'(FIFO_DEPTH));
    push       = tx_valid && tx_ready;
    fifo_empty = (count_q == '0);
    baud_done  = (baud_q == BW'(CLKS_PER_BIT - 1));
  end

  // Next-state logic: bit timing, shifting and popping the FIFO head.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = mem[rd_ptr_q];
            bit_idx_d = 3'd0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Line level for the next cycle, taken from the current FSM state.
  always_comb begin
    case (state_q)
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift_q[0];
      default: tx_serial_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and drops queued bytes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_serial_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  assign tx_serial  = tx_serial_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo with 4 clocks per
// bit and a 4-entry FIFO. A line-level UART receiver decodes every frame
// and the decoded bytes are compared with the bytes the bench handed over.
module tb_uart_tx_fifo;

  logic       CLK;
  logic       RST;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       busy;
  logic [2:0] fifo_count;

  int         errors = 0;
  int         checks = 0;
  logic       mon_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  time        start_times[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, (n < 2000), 1);
    repeat (6) tick();
  endtask

  // Line receiver: a bit lasts 40 time units, sampled at its middle.
  always begin
    logic [7:0] b;
    time        t0;
    @(negedge tx_serial);
    if (mon_en && !RST) begin
      t0 = $time;
      start_times.push_back(t0);
      #20;
      check("mon_start_bit", tx_serial, 0);
      for (int i = 0; i < 8; i++) begin
        #40;
        b[i] = tx_serial;
      end
      #40;
      check("mon_stop_bit", tx_serial, 1);
      rx_q.push_back(b);
    end
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] v;
    logic       acc;
    int         n;
    int         s;

    RST      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset values while held and after release.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hold_tx", tx_serial, 1);
    RST = 1'b0;
    tick();
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);

    // Single byte 0xA5, checked cycle by cycle on the line.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(8'hA5);
    check("single_count_after_push", fifo_count, 1);
    check("single_busy", busy, 1);
    tick();
    check("single_count_after_pop", fifo_count, 0);
    check("single_tx_before_start", tx_serial, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) begin
      tick();
      check($sformatf("single_line_c%0d", j), tx_serial, frame[j / 4]);
      if (j == 38) check("single_busy_in_stop", busy, 1);
      if (j == 39) check("single_busy_drop", busy, 0);
    end
    wait_drain("single_drain");

    // Back-to-back 0x00 then 0xFF on consecutive cycles.
    s        = start_times.size();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check("b2b_count", fifo_count, 1);
    tick();
    check("b2b_first_start", tx_serial, 0);
    repeat (38) tick();
    check("b2b_stop_bit", tx_serial, 1);
    tick();
    check("b2b_stop_tail", tx_serial, 1);
    tick();
    check("b2b_second_start", tx_serial, 0);
    wait_drain("b2b_drain");
    check("b2b_frames_seen", start_times.size() - s, 2);
    if (start_times.size() >= s + 2)
      check("b2b_start_spacing", 32'(start_times[s + 1] - start_times[s]), 400);

    // Full FIFO: 0x11..0x16 with valid held until accepted.
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h11 + 8'(i);
      tick();
      exp_q.push_back(tx_data);
      check($sformatf("full_count_%0d", i), fifo_count, (i == 0) ? 1 : i);
    end
    check("full_ready_low", tx_ready, 0);
    tx_data = 8'h16;
    repeat (36) tick();
    check("full_still_full", fifo_count, 4);
    check("full_still_not_ready", tx_ready, 0);
    tick();
    check("full_count_after_pop", fifo_count, 3);
    check("full_ready_back", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(8'h16);
    check("full_held_byte_taken", fifo_count, 4);
    check("full_ready_low_again", tx_ready, 0);
    wait_drain("full_drain");

    // Push exactly at the stop-bit end with two bytes queued.
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v       = 8'($urandom);
      tx_data = v;
      tick();
      exp_q.push_back(v);
    end
    tx_valid = 1'b0;
    check("simul_count_before", fifo_count, 2);
    repeat (38) tick();
    v        = 8'($urandom);
    tx_data  = v;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    exp_q.push_back(v);
    check("simul_count_kept", fifo_count, 2);
    check("simul_stop_tail", tx_serial, 1);
    tick();
    check("simul_next_start", tx_serial, 0);
    wait_drain("simul_drain");

    // Pointer wrap: 20 bytes with random throttling.
    for (int b = 0; b < 20; b++) begin
      tx_data  = 8'(b);
      tx_valid = 1'b1;
      n        = 0;
      do begin
        acc = tx_ready;
        tick();
        n++;
      end while (!acc && n < 500);
      check($sformatf("wrap_accept_%0d", b), acc, 1);
      tx_valid = 1'b0;
      exp_q.push_back(8'(b));
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_drain("wrap_drain");

    // Every accepted byte must come out once, in order.
    check("rx_byte_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("rx_byte_%0d", i), v, exp_q[i]);
    end

    // Reset in the middle of a data bit.
    mon_en   = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_data  = 8'h5A;
    tick();
    tx_data  = 8'h3C;
    tick();
    tx_valid = 1'b0;
    repeat (10) tick();
    check("midrst_line_low", tx_serial, 0);
    check("midrst_busy_before", busy, 1);
    #3;
    RST = 1'b1;
    #1;
    check("midrst_tx_high", tx_serial, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (2) tick();
    RST = 1'b0;
    repeat (60) tick();
    check("midrst_line_idle", tx_serial, 1);
    check("midrst_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
